mult_rr_scheduler: RTL and testbench
====================================

// Module: mult_rr_scheduler
// PURPOSE
//  Time-shares one WIDTH x WIDTH unsigned multiplier between NREQ requesters.
//  A round-robin arbiter picks one pending request and latches its operands.
//  The block then computes and registers the product, and holds the result
//  with a requester tag until the consumer accepts it.
//  It sits between the requesting blocks and the shared multiplier datapath.
// PARAMETERS
//  NREQ   4  number of requesters (2..8); ID_W = $clog2(NREQ), derived localparam
//  WIDTH  4  operand width; product width is 2*WIDTH
// PORTS
//  clk        in   1             rising-edge clock
//  rst        in   1             reset, asynchronous, active-high
//  req        in   NREQ          request per requester; held until its ack
//  a_in       in   NREQ*WIDTH    operand A; requester i on bits [i*WIDTH +: WIDTH]
//  b_in       in   NREQ*WIDTH    operand B; same packing as a_in
//  ack        out  NREQ          one-hot, 1-cycle pulse: operands of requester i taken
//  busy       out  1             high in CALC and DONE
//  out_valid  out  1             result available
//  out_ready  in   1             consumer accepts the result when out_valid & out_ready
//  out_prod   out  2*WIDTH       registered product a*b (unsigned, full width, no truncation)
//  out_id     out  ID_W          index of the requester that owns out_prod
// BEHAVIOUR
//  Reset values: state=IDLE, ptr=0, ack=0, busy=0, out_valid=0, out_prod=0, out_id=0.
//  All outputs are registered.
//  FSM states:
//   IDLE: if |req, pick the winner = first i with req[i]=1, searching ptr, ptr+1, ...
//         modulo NREQ. Latch a_in/b_in slices and id. Set ack[winner] for the next
//         cycle. Set ptr = (winner+1) mod NREQ. Go to CALC. If req==0, stay in IDLE.
//   CALC: ack pulse is high in this cycle only. Register prod = a_lat*b_lat and
//         out_id. Go to DONE.
//   DONE: out_valid=1; out_prod and out_id are stable. On out_valid & out_ready,
//         clear out_valid and go to IDLE.
//  Latency: req sampled at edge N -> ack high in cycle N+1 -> out_valid high from
//   edge N+2. Minimum spacing between grants is 3 cycles.
//  Requesters: keep req and operands stable until ack is seen, then drop req
//   within 1 cycle. req is sampled only in IDLE; changes in CALC/DONE are ignored.
//  Backpressure: DONE is held indefinitely while out_ready=0. No further acks are
//   issued in that time. Pending requests wait.
//  Fairness: a requester holding req is granted within NREQ grants.
//   ptr wraps from NREQ-1 to 0.
//  Simultaneous events: req arriving in the same cycle as the DONE->IDLE transition
//   is sampled on the following edge (one IDLE cycle between transactions).
//  Reset mid-operation: the in-flight transaction is dropped and no result is
//   emitted. Outputs clear immediately (asynchronous); ptr returns to 0.
//  out_ready while out_valid=0: ignored.
// TESTING (NREQ=4, WIDTH=4)
//  1) req=0001, a0=6, b0=6 -> ack=0001 in cycle 1; out_valid in cycle 2 with
//     out_prod=8'd36, out_id=0; out_ready=1 -> IDLE, busy=0.
//  2) From reset, req=1111, a_i=7, b_i=i+2, out_ready=1 -> grants in order 0,1,2,3;
//     products 14,21,28,35; each req drops after its ack.
//  3) req0 and req2 continuously re-asserted -> grants alternate 0,2,0,2.
//     ptr wraps correctly and no requester is starved.
//  4) Result pending with out_ready=0 for 5 cycles while req1 is pending ->
//     out_valid held, out_prod/out_id stable, ack stays 0; release -> req1 acked.
//  5) Boundary operands: 15*15 -> 8'd225; 0*9 -> 0; 1*15 -> 15 (no truncation).
//  6) rst pulsed during CALC -> in the same cycle out_valid=0, ack=0, busy=0.
//     After release, req=1000 is granted to id 3 via a search starting at ptr=0.

Source files
------------

// File: rtl/mult_rr_scheduler_if.sv
// rtl/mult_rr_scheduler_if.sv - requester/consumer bus for the shared multiplier scheduler
interface mult_rr_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       ack;
    logic                  busy;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*WIDTH-1:0]    out_prod;
    logic [ID_W-1:0]       out_id;

    // Requesters and result consumer side
    modport master (
        output req, a_in, b_in, out_ready,
        input  ack, busy, out_valid, out_prod, out_id
    );

    // Scheduler side
    modport slave (
        input  req, a_in, b_in, out_ready,
        output ack, busy, out_valid, out_prod, out_id
    );
endinterface

// File: rtl/mult_rr_scheduler.sv
// rtl/mult_rr_scheduler.sv - round-robin time-sharing of one unsigned multiplier
module mult_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_rr_scheduler_if.slave   bus
);
    localparam int ID_W = $clog2(NREQ);
    localparam int SW   = ID_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    // Round-robin pointer and latched operands of the current owner
    logic [ID_W-1:0]    ptr, ptr_nx;
    logic [WIDTH-1:0]   a_lat, a_lat_nx;
    logic [WIDTH-1:0]   b_lat, b_lat_nx;
    logic [ID_W-1:0]    id_lat, id_lat_nx;

    // Registered outputs and their next values
    logic [NREQ-1:0]    ack_q, ack_nx;
    logic               busy_q, busy_nx;
    logic               valid_q, valid_nx;
    logic [2*WIDTH-1:0] prod_q, prod_nx;
    logic [ID_W-1:0]    out_id_q, out_id_nx;

    // Arbitration result
    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [SW-1:0]      cand;
    logic [WIDTH-1:0]   a_sel, b_sel;

    // Search ptr, ptr+1, ... modulo NREQ for the first pending request
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + SW'(k);
            if (cand >= SW'(NREQ)) begin
                cand = cand - SW'(NREQ);
            end
            if (!win_found && bus.req[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[ID_W-1:0];
            end
        end
    end

    // Select the winner's operand slices
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == ID_W'(i)) begin
                a_sel = bus.a_in[i*WIDTH +: WIDTH];
                b_sel = bus.b_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        a_lat_nx  = a_lat;
        b_lat_nx  = b_lat;
        id_lat_nx = id_lat;
        ack_nx    = '0;
        busy_nx   = busy_q;
        valid_nx  = valid_q;
        prod_nx   = prod_q;
        out_id_nx = out_id_q;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nx       = CALC;
                    a_lat_nx       = a_sel;
                    b_lat_nx       = b_sel;
                    id_lat_nx      = win_id;
                    ack_nx[win_id] = 1'b1;
                    busy_nx        = 1'b1;
                    if (win_id == ID_W'(NREQ - 1)) begin
                        ptr_nx = '0;
                    end else begin
                        ptr_nx = win_id + 1'b1;
                    end
                end
            end
            CALC: begin
                state_nx  = DONE;
                prod_nx   = {{WIDTH{1'b0}}, a_lat} * {{WIDTH{1'b0}}, b_lat};
                out_id_nx = id_lat;
                valid_nx  = 1'b1;
                busy_nx   = 1'b1;
            end
            DONE: begin
                // Result is held here for as long as the consumer stalls
                if (bus.out_ready) begin
                    state_nx = IDLE;
                    valid_nx = 1'b0;
                    busy_nx  = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
                valid_nx = 1'b0;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Pointer, operand latches and output registers; reset drops any transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            a_lat    <= '0;
            b_lat    <= '0;
            id_lat   <= '0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            prod_q   <= '0;
            out_id_q <= '0;
        end else begin
            ptr      <= ptr_nx;
            a_lat    <= a_lat_nx;
            b_lat    <= b_lat_nx;
            id_lat   <= id_lat_nx;
            ack_q    <= ack_nx;
            busy_q   <= busy_nx;
            valid_q  <= valid_nx;
            prod_q   <= prod_nx;
            out_id_q <= out_id_nx;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = valid_q;
    assign bus.out_prod  = prod_q;
    assign bus.out_id    = out_id_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// tb/tb_mult_rr_scheduler.sv - randomized and directed bench for mult_rr_scheduler
module tb_mult_rr_scheduler;
    localparam int N = 4;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_rr_scheduler_if #(.NREQ(N), .WIDTH(W)) bus ();

    mult_rr_scheduler #(.NREQ(N), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level reference model
    int m_phase;      // 0 waiting for request, 1 ack cycle, 2 result held
    int m_ptr;
    int m_ack;
    int m_valid;
    int m_prod;
    int m_id;
    int m_pend_prod;
    int m_pend_id;

    bit           auto_req = 1'b0;
    logic [N-1:0] hold_mask = '0;
    int           grants[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_ptr   = 0;
        m_ack   = 0;
        m_valid = 0;
        m_prod  = 0;
        m_id    = 0;
    endtask

    // Advance the model by one rising edge using the inputs currently driven
    task automatic model_edge();
        int win;
        int idx;
        if (rst) begin
            model_reset();
            return;
        end
        case (m_phase)
            0: begin
                m_ack = 0;
                win   = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (win < 0 && ((int'(bus.req) >> idx) & 1) != 0) win = idx;
                end
                if (win >= 0) begin
                    m_ack       = 1 << win;
                    m_pend_prod = ((int'(bus.a_in) >> (win * W)) & ((1 << W) - 1)) *
                                  ((int'(bus.b_in) >> (win * W)) & ((1 << W) - 1));
                    m_pend_id   = win;
                    m_ptr       = (win + 1) % N;
                    m_phase     = 1;
                end
            end
            1: begin
                m_ack   = 0;
                m_prod  = m_pend_prod;
                m_id    = m_pend_id;
                m_valid = 1;
                m_phase = 2;
            end
            default: begin
                m_ack = 0;
                if (bus.out_ready) begin
                    m_valid = 0;
                    m_phase = 0;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        check("ack", bus.ack, m_ack);
        check("busy", bus.busy, m_phase != 0);
        check("out_valid", bus.out_valid, m_valid);
        check("out_prod", bus.out_prod, m_prod);
        check("out_id", bus.out_id, m_id);
    endtask

    // One clock: model edge, compare on the falling edge, then update requesters
    task automatic tick();
        model_edge();
        @(negedge clk);
        check_outputs();
        for (int i = 0; i < N; i++) begin
            if (bus.ack[i]) grants.push_back(i);
        end
        for (int i = 0; i < N; i++) begin
            if (((m_ack >> i) & 1) != 0) begin
                bus.req[i] = 1'b0;
            end else if (!bus.req[i] && (hold_mask[i] || (auto_req && $urandom_range(0, 2) == 0))) begin
                bus.req[i] = 1'b1;
                if (auto_req) begin
                    bus.a_in[i*W +: W] = W'($urandom);
                    bus.b_in[i*W +: W] = W'($urandom);
                end
            end
        end
        if (auto_req) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
    endtask

    initial begin
        bus.req       = '0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.out_ready = 1'b0;
        model_reset();

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // Single request 6*6
        bus.a_in[3:0] = 4'd6;
        bus.b_in[3:0] = 4'd6;
        bus.req       = 4'b0001;
        bus.out_ready = 1'b1;
        tick();
        check("t1_ack", bus.ack, 4'b0001);
        tick();
        check("t1_valid", bus.out_valid, 1);
        check("t1_prod", bus.out_prod, 36);
        check("t1_id", bus.out_id, 0);
        tick();
        check("t1_busy", bus.busy, 0);

        // All four requesting from reset: grants 0,1,2,3
        do_reset();
        bus.a_in = {4'd7, 4'd7, 4'd7, 4'd7};
        bus.b_in = {4'd5, 4'd4, 4'd3, 4'd2};
        bus.req  = 4'b1111;
        bus.out_ready = 1'b1;
        grants.delete();
        repeat (14) tick();
        check("t2_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++) check("t2_order", grants[i], i);

        // Requesters 0 and 2 continuously re-asserting: alternate grants
        bus.a_in[3:0]  = 4'd3;
        bus.b_in[3:0]  = 4'd4;
        bus.a_in[11:8] = 4'd5;
        bus.b_in[11:8] = 4'd2;
        hold_mask = 4'b0101;
        bus.req   = 4'b0101;
        grants.delete();
        repeat (16) tick();
        check("t3_enough", grants.size() >= 4, 1);
        for (int i = 0; i < 4 && i < grants.size(); i++) check("t3_alt", grants[i], (i % 2) * 2);
        hold_mask = '0;
        repeat (10) tick();

        // Backpressure with requester 1 waiting
        bus.out_ready = 1'b0;
        bus.a_in[3:0] = 4'd3;
        bus.b_in[3:0] = 4'd5;
        bus.req       = 4'b0001;
        tick();
        check("t4_ack0", bus.ack, 4'b0001);
        bus.req[1]    = 1'b1;
        bus.a_in[7:4] = 4'd2;
        bus.b_in[7:4] = 4'd9;
        tick();
        repeat (5) begin
            tick();
            check("t4_hold_ack", bus.ack, 0);
            check("t4_hold_valid", bus.out_valid, 1);
            check("t4_hold_prod", bus.out_prod, 15);
        end
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("t4_ack1", bus.ack, 4'b0010);
        tick();
        check("t4_prod1", bus.out_prod, 18);
        check("t4_id1", bus.out_id, 1);
        tick();

        // Boundary operands
        begin
            int tbl[3][4] = '{'{3, 15, 15, 225}, '{1, 0, 9, 0}, '{2, 1, 15, 15}};
            for (int t = 0; t < 3; t++) begin
                bus.a_in[tbl[t][0]*W +: W] = W'(tbl[t][1]);
                bus.b_in[tbl[t][0]*W +: W] = W'(tbl[t][2]);
                bus.req = N'(1 << tbl[t][0]);
                tick();
                tick();
                check("t5_prod", bus.out_prod, tbl[t][3]);
                check("t5_id", bus.out_id, tbl[t][0]);
                tick();
            end
        end

        // Reset pulse during CALC, then id 3 from ptr=0
        bus.a_in[7:4] = 4'd3;
        bus.b_in[7:4] = 4'd3;
        bus.req = 4'b0010;
        tick();
        check("t6_calc_ack", bus.ack, 4'b0010);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", bus.out_valid, 0);
        check("t6_rst_ack", bus.ack, 0);
        check("t6_rst_busy", bus.busy, 0);
        model_reset();
        bus.req = 4'b1000;
        bus.a_in[15:12] = 4'd4;
        bus.b_in[15:12] = 4'd5;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("t6_ack3", bus.ack, 4'b1000);
        tick();
        check("t6_id", bus.out_id, 3);
        check("t6_prod", bus.out_prod, 20);
        tick();

        // Randomized traffic with random backpressure
        auto_req = 1'b1;
        repeat (600) tick();
        auto_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
